branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of branch statistics counters.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port br_valid, input, 1, decode presents a branch.
REQ-005 SHALL have port br_ready, output, 1, block can accept a branch.
REQ-006 SHALL have port br_func, input, 3, compare code: 0 GTZ, 1 GEZ, 2 LTZ, 3 LEZ, 4 EQ, 5 NE, 6-7 illegal.
REQ-007 SHALL have port br_pc4, input, 32, PC+4 of the branch.
REQ-008 SHALL have port br_off, input, 16, signed word offset.
REQ-009 SHALL have ports rs_val / rt_val, input, 32 each, forwarded operand values.
REQ-010 SHALL have ports rs_rdy / rt_rdy, input, 1 each, forwarded operand valid.
REQ-011 SHALL have port br_kill, input, 1, exception flush; abort any branch in flight.
REQ-012 SHALL have ports cmp_a / cmp_b, output, 32 each, and cmp_func, output, 3, registered drive of the shared comparator.
REQ-013 SHALL have port cmp_y, input, 1, comparator result (combinational from cmp_a/cmp_b/cmp_func).
REQ-014 SHALL have port stall, output, 1, high whenever state != IDLE.
REQ-015 SHALL have ports res_valid, output, 1 (one-cycle pulse), and res_taken, output, 1.
REQ-016 SHALL have ports redirect_valid, output, 1 (one-cycle pulse), and redirect_pc, output, 32.
REQ-017 SHALL have port err_func, output, 1, one-cycle pulse on illegal br_func.
REQ-018 SHALL have ports cnt_total / cnt_taken, output, CNT_W each, resolved / taken branch counts.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, EVAL, REDIR; br_ready = (state == IDLE) && !br_kill.
REQ-020 IDLE: on br_valid && br_ready, SHALL latch func, target = br_pc4 + (sign_ext(br_off) << 2) (mod 2^32), and go to WAIT.
REQ-021 Acceptance with func 6-7: SHALL pulse err_func next cycle, remain in IDLE, and leave counters unchanged.
REQ-022 WAIT: operands needed are rs only (func 0-3) or rs and rt (func 4-5); when all needed rdy are high, SHALL register cmp_a=rs_val, cmp_b=rt_val (or 0 if unused), cmp_func=func, and go to EVAL; otherwise stay in WAIT indefinitely.
REQ-023 EVAL: SHALL sample cmp_y on the next edge; set res_valid=1, res_taken=cmp_y; increment cnt_total, and cnt_taken if taken; go to REDIR if taken, else to IDLE.
REQ-024 REDIR: redirect_valid=1, redirect_pc=target for exactly this one cycle; next state IDLE.
REQ-025 Latency with operands ready at acceptance: res_valid high in cycle after 2nd edge after acceptance edge; redirect_valid in the same cycle; br_ready high again one cycle later (taken) or same cycle (not taken).
REQ-026 Counters SHALL wrap modulo 2^CNT_W, no saturation.
REQ-027 br_kill SHALL have priority: any state goes to IDLE next edge, no res_valid/redirect_valid/count update; br_valid concurrent with br_kill SHALL NOT be accepted.
REQ-028 br_kill in REDIR cycle SHALL not suppress the already-asserted redirect but SHALL still force IDLE.
REQ-029 redirect_pc SHALL hold its last value when redirect_valid is low.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, cmp_a=cmp_b=0, cmp_func=0, res_valid=res_taken=redirect_valid=err_func=0, redirect_pc=0, counters=0; mid-branch reset discards the branch.

Verification
REQ-031 BEQ, rs=rt=5 ready, pc4=0x100, off=4 -> res_taken=1, redirect_pc=0x110 two edges after accept, cnt_taken=1.
REQ-032 BGTZ, rs=0 ready -> res_valid=1, res_taken=0, no redirect, br_ready back the same cycle; cnt_total=1, cnt_taken=0.
REQ-033 BNE with rt_rdy low for 3 cycles, rs=1, rt=2 -> stall high through wait, redirect 2 edges after rt_rdy rises.
REQ-034 BLTZ rs=0x80000000, off=0xFFFF, pc4=0x8 -> taken, redirect_pc=0x4; br_kill in EVAL -> no res_valid, counters unchanged.
REQ-035 br_func=7 -> err_func single pulse, state stays IDLE; cnt_total wraps from 0xFFFF to 0 after one more branch.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accepts a branch from decode, waits for its
// forwarded operands, drives the shared comparator, reports the outcome and
// issues a one-cycle fetch redirect for taken branches. Keeps resolved/taken
// statistics counters.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_func,
    input  logic [31:0]      br_pc4,
    input  logic [15:0]      br_off,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_rdy,
    input  logic             rt_rdy,
    input  logic             br_kill,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    output logic [2:0]       cmp_func,
    input  logic             cmp_y,
    output logic             stall,
    output logic             res_valid,
    output logic             res_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             err_func,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        EVAL  = 2'd2,
        REDIR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       func_q;
    logic [31:0]      target_q;
    logic [31:0]      cmp_a_q, cmp_b_q;
    logic [2:0]       cmp_func_q;
    logic             res_valid_q, res_taken_q;
    logic             redir_valid_q;
    logic [31:0]      redir_pc_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_total_q, cnt_taken_q;

    logic accept, func_ok, ops_ok, go_eval, resolve;

    assign br_ready = (state_q == IDLE) && !br_kill;
    assign accept   = br_valid && br_ready;
    // codes 6 and 7 are the only illegal ones
    assign func_ok  = !(br_func[2] && br_func[1]);
    // EQ/NE (func[2] set) need rt as well as rs
    assign ops_ok   = rs_rdy && (!func_q[2] || rt_rdy);
    assign go_eval  = (state_q == WAIT) && ops_ok && !br_kill;
    assign resolve  = (state_q == EVAL) && !br_kill;

    // Next-state logic; a kill always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        if (br_kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && func_ok) state_d = WAIT;
                WAIT:    if (ops_ok) state_d = EVAL;
                EVAL:    state_d = cmp_y ? REDIR : IDLE;
                REDIR:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture compare code and branch target at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q   <= 3'd0;
            target_q <= 32'd0;
        end else if (accept && func_ok) begin
            func_q   <= br_func;
            target_q <= br_pc4 + {{14{br_off[15]}}, br_off, 2'b00};
        end
    end

    // Comparator drive; rt is zeroed for the compare-with-zero forms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_a_q    <= 32'd0;
            cmp_b_q    <= 32'd0;
            cmp_func_q <= 3'd0;
        end else if (go_eval) begin
            cmp_a_q    <= rs_val;
            cmp_b_q    <= func_q[2] ? rt_val : 32'd0;
            cmp_func_q <= func_q;
        end
    end

    // Outcome, redirect and illegal-code pulses; redirect_pc holds between uses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            err_q         <= 1'b0;
        end else begin
            res_valid_q   <= resolve;
            redir_valid_q <= resolve && cmp_y;
            err_q         <= accept && !func_ok;
            if (resolve) res_taken_q <= cmp_y;
            if (resolve && cmp_y) redir_pc_q <= target_q;
        end
    end

    // Statistics counters, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_taken_q <= '0;
        end else if (resolve) begin
            cnt_total_q <= cnt_total_q + 1'b1;
            if (cmp_y) cnt_taken_q <= cnt_taken_q + 1'b1;
        end
    end

    assign stall          = (state_q != IDLE);
    assign cmp_a          = cmp_a_q;
    assign cmp_b          = cmp_b_q;
    assign cmp_func       = cmp_func_q;
    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign err_func       = err_q;
    assign cnt_total      = cnt_total_q;
    assign cnt_taken      = cnt_taken_q;

endmodule
